pulse_checker: RTL and testbench

//  Receive-side monitor for the BIST pulse-train interface (running / out / bist_end).
//  - Expected train: M_PULSES pulses, each N_HIGH cycles high then N_LOW cycles low, then bist_end.
//  - Reports pass/fail, an error code and the pulse count.
//  - Sits beside the pulse controller in the top level; also reused as a self-check in benches.

---
 rtl/pulse_checker.sv | 235 +++++++++++++++++++++++
 tb/tb_pulse_checker.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_checker.sv
`default_nettype none
// ============================================================================
// Module   : pulse_checker
// Purpose  : Receive-side monitor for a BIST pulse train (running/pulse/bist_end);
//            reports pass/fail, an error code and the count of good pulses.
// Options  : PULSE_CHK_TIMESTAMP_EN adds fail_cycle (cycles from arm to fail).
// Revision : 1.0  initial release
// ============================================================================
module pulse_checker #(
    parameter int N_HIGH   = 8,
    parameter int N_LOW    = 1,
    parameter int M_PULSES = 9,
    parameter int START_TO = 4,
    parameter int END_TO   = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            running_in,
    input  logic                            pulse_in,
    input  logic                            bist_end_in,
    output logic                            busy,
    output logic                            pass,
    output logic                            fail,
    output logic [2:0]                      err_code,
    output logic [$clog2(M_PULSES+1)-1:0]   pulse_count
`ifdef PULSE_CHK_TIMESTAMP_EN
    ,
    output logic [15:0]                     fail_cycle
`endif
);

    localparam int CW     = $clog2(M_PULSES + 1);
    localparam int HW     = $clog2(N_HIGH + 1);
    localparam int LW     = $clog2(N_LOW + 1);
    localparam int TO_MAX = (START_TO > END_TO) ? START_TO : END_TO;
    localparam int TW     = $clog2(TO_MAX + 1);

    localparam logic [CW-1:0] c_M_PULSES = CW'(M_PULSES);
    localparam logic [HW-1:0] c_N_HIGH   = HW'(N_HIGH);
    localparam logic [LW-1:0] c_N_LOW    = LW'(N_LOW);
    localparam logic [TW-1:0] c_START_TO = TW'(START_TO);
    localparam logic [TW-1:0] c_END_TO   = TW'(END_TO);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_ARMED    = 3'd1;
    localparam logic [2:0] c_HIGH     = 3'd2;
    localparam logic [2:0] c_LOW      = 3'd3;
    localparam logic [2:0] c_WAIT_END = 3'd4;
    localparam logic [2:0] c_DONE     = 3'd5;

    localparam logic [2:0] c_ERR_WIDTH   = 3'd1;
    localparam logic [2:0] c_ERR_GAP     = 3'd2;
    localparam logic [2:0] c_ERR_COUNT   = 3'd3;
    localparam logic [2:0] c_ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] c_ERR_ABORT   = 3'd5;

    logic [2:0]    r_state, w_state;
    logic [HW-1:0] r_hi_cnt, w_hi_cnt;
    logic [LW-1:0] r_lo_cnt, w_lo_cnt;
    logic [TW-1:0] r_to_cnt, w_to_cnt;
    logic          r_gap_long, w_gap_long;
    logic          r_run_prev;
    logic          r_busy, w_busy;
    logic          r_pass, w_pass;
    logic          r_fail, w_fail;
    logic [2:0]    r_err, w_err;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [2:0]    w_code;
    logic          w_arm;

    always_comb begin
        w_state    = r_state;
        w_hi_cnt   = r_hi_cnt;
        w_lo_cnt   = r_lo_cnt;
        w_to_cnt   = r_to_cnt;
        w_gap_long = r_gap_long;
        w_pass     = r_pass;
        w_fail     = r_fail;
        w_err      = r_err;
        w_cnt      = r_cnt;
        w_code     = 3'd0;
        w_arm      = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (running_in) w_arm = 1'b1;
            end
            c_DONE: begin
                // Re-arm only on a fresh rising edge of running_in.
                if (running_in && !r_run_prev) w_arm = 1'b1;
                else if (!running_in)          w_state = c_IDLE;
            end
            default: begin
                if (!running_in)
                    w_code = c_ERR_ABORT;
                else if (bist_end_in && r_state != c_WAIT_END)
                    w_code = c_ERR_COUNT;
                else begin
                    case (r_state)
                        c_ARMED: begin
                            if (pulse_in) begin
                                w_state  = c_HIGH;
                                w_hi_cnt = HW'(1);
                            end else if (r_to_cnt == c_START_TO)
                                w_code = c_ERR_TIMEOUT;
                            else
                                w_to_cnt = r_to_cnt + 1'b1;
                        end
                        c_HIGH: begin
                            if (pulse_in) begin
                                if (r_hi_cnt == c_N_HIGH) w_code = c_ERR_WIDTH;
                                else                      w_hi_cnt = r_hi_cnt + 1'b1;
                            end else if (r_hi_cnt != c_N_HIGH)
                                w_code = c_ERR_WIDTH;
                            else begin
                                if (r_cnt != c_M_PULSES) w_cnt = r_cnt + 1'b1;
                                w_state    = c_LOW;
                                w_lo_cnt   = LW'(1);
                                w_gap_long = 1'b0;
                            end
                        end
                        c_LOW: begin
                            if (pulse_in) begin
                                if (r_cnt == c_M_PULSES)
                                    w_code = c_ERR_COUNT;
                                else if (r_lo_cnt != c_N_LOW || r_gap_long)
                                    w_code = c_ERR_GAP;
                                else begin
                                    w_state  = c_HIGH;
                                    w_hi_cnt = HW'(1);
                                end
                            end else if (r_lo_cnt == c_N_LOW) begin
                                if (r_cnt == c_M_PULSES) begin
                                    w_state  = c_WAIT_END;
                                    w_to_cnt = '0;
                                end else
                                    w_gap_long = 1'b1;  // gap overran; next rise is an error
                            end else
                                w_lo_cnt = r_lo_cnt + 1'b1;
                        end
                        c_WAIT_END: begin
                            if (pulse_in)
                                w_code = c_ERR_COUNT;
                            else if (bist_end_in) begin
                                w_pass  = 1'b1;
                                w_state = c_DONE;
                            end else if (r_to_cnt == c_END_TO)
                                w_code = c_ERR_TIMEOUT;
                            else
                                w_to_cnt = r_to_cnt + 1'b1;
                        end
                        default: w_state = c_IDLE;
                    endcase
                end
            end
        endcase

        if (w_code != 3'd0) begin
            w_fail  = 1'b1;
            w_err   = w_code;
            w_state = c_DONE;
        end

        if (w_arm) begin
            w_pass     = 1'b0;
            w_fail     = 1'b0;
            w_err      = 3'd0;
            w_cnt      = '0;
            w_lo_cnt   = '0;
            w_gap_long = 1'b0;
            w_hi_cnt   = pulse_in ? HW'(1) : '0;
            w_to_cnt   = pulse_in ? '0 : TW'(1);
            w_state    = pulse_in ? c_HIGH : c_ARMED;
        end

        w_busy = (w_state == c_ARMED) || (w_state == c_HIGH) ||
                 (w_state == c_LOW)   || (w_state == c_WAIT_END);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_IDLE;
            r_hi_cnt   <= '0;
            r_lo_cnt   <= '0;
            r_to_cnt   <= '0;
            r_gap_long <= 1'b0;
            r_run_prev <= 1'b0;
            r_busy     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_err      <= 3'd0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state;
            r_hi_cnt   <= w_hi_cnt;
            r_lo_cnt   <= w_lo_cnt;
            r_to_cnt   <= w_to_cnt;
            r_gap_long <= w_gap_long;
            r_run_prev <= running_in;
            r_busy     <= w_busy;
            r_pass     <= w_pass;
            r_fail     <= w_fail;
            r_err      <= w_err;
            r_cnt      <= w_cnt;
        end
    end

`ifdef PULSE_CHK_TIMESTAMP_EN
    logic [15:0] r_cyc, r_fail_cycle, w_cyc_inc;
    assign w_cyc_inc = (r_cyc == 16'hFFFF) ? r_cyc : r_cyc + 16'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cyc        <= 16'd0;
            r_fail_cycle <= 16'd0;
        end else if (w_arm) begin
            r_cyc        <= 16'd0;
            r_fail_cycle <= 16'd0;
        end else if (r_busy) begin
            r_cyc <= w_cyc_inc;
            if (w_fail) r_fail_cycle <= w_cyc_inc;
        end
    end

    assign fail_cycle = r_fail_cycle;
`endif

    assign busy        = r_busy;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign err_code    = r_err;
    assign pulse_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pulse_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_checker
// Purpose  : Directed self-checking bench for pulse_checker (default parameters).
// Revision : 1.0  initial release
// ============================================================================
module tb_pulse_checker;

    logic        clk;
    logic        reset_n;
    logic        running_in;
    logic        pulse_in;
    logic        bist_end_in;
    logic        busy;
    logic        pass;
    logic        fail;
    logic [2:0]  err_code;
    logic [3:0]  pulse_count;
`ifdef PULSE_CHK_TIMESTAMP_EN
    logic [15:0] fail_cycle;
`endif

    int n_vec = 0;
    int n_err = 0;

    pulse_checker dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .running_in  (running_in),
        .pulse_in    (pulse_in),
        .bist_end_in (bist_end_in),
        .busy        (busy),
        .pass        (pass),
        .fail        (fail),
        .err_code    (err_code),
        .pulse_count (pulse_count)
`ifdef PULSE_CHK_TIMESTAMP_EN
        ,
        .fail_cycle  (fail_cycle)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic run, input logic p, input logic e);
        running_in  = run;
        pulse_in    = p;
        bist_end_in = e;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pulse(input int hi, input int lo);
        repeat (hi) cyc(1'b1, 1'b1, 1'b0);
        repeat (lo) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_result(input string tag, input logic f, input logic [2:0] code,
                                input logic [3:0] cnt);
        check({tag, "_fail"}, 16'(fail), 16'(f));
        check({tag, "_pass"}, 16'(pass), 16'(!f));
        check({tag, "_err"},  16'(err_code), 16'(code));
        check({tag, "_cnt"},  16'(pulse_count), 16'(cnt));
        check({tag, "_busy"}, 16'(busy), 16'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        running_in  = 1'b0;
        pulse_in    = 1'b0;
        bist_end_in = 1'b0;
        #12;
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_pass", 16'(pass), 16'd0);
        check("rst_fail", 16'(fail), 16'd0);
        check("rst_err",  16'(err_code), 16'd0);
        check("rst_cnt",  16'(pulse_count), 16'd0);
        reset_n = 1'b1;
        idle(1);

        // Good train: 9 x (8 high, 1 low), one more low, then bist_end
        repeat (4) send_pulse(8, 1);
        check("good_mid_cnt",  16'(pulse_count), 16'd4);
        check("good_mid_busy", 16'(busy), 16'd1);
        repeat (5) send_pulse(8, 1);
        cyc(1'b1, 1'b0, 1'b0);
        check("good_wait_busy", 16'(busy), 16'd1);
        cyc(1'b1, 1'b0, 1'b1);
        check_result("good", 1'b0, 3'd0, 4'd9);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("no_rearm_busy", 16'(busy), 16'd0);
        check("no_rearm_pass", 16'(pass), 16'd1);
        idle(1);
        check("idle_hold_pass", 16'(pass), 16'd1);

        // Pulse 3 only 7 cycles high
        repeat (2) send_pulse(8, 1);
        send_pulse(7, 1);
        check_result("short", 1'b1, 3'd1, 4'd2);
        idle(1);

        // Two-cycle gap after pulse 1
        send_pulse(8, 2);
        cyc(1'b1, 1'b1, 1'b0);
        check_result("gap", 1'b1, 3'd2, 4'd1);
        idle(1);

        // bist_end after 5 pulses
        repeat (5) send_pulse(8, 1);
        cyc(1'b1, 1'b0, 1'b1);
        check_result("early_end", 1'b1, 3'd3, 4'd5);
        idle(1);

        // 10th pulse instead of bist_end
        repeat (9) send_pulse(8, 1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        check_result("extra", 1'b1, 3'd3, 4'd9);
        idle(1);

        // bist_end never arrives: 5 waiting cycles allowed, timeout on the next
        repeat (9) send_pulse(8, 1);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (4) cyc(1'b1, 1'b0, 1'b0);
        check("end_to_edge_fail", 16'(fail), 16'd0);
        cyc(1'b1, 1'b0, 1'b0);
        check_result("end_to", 1'b1, 3'd4, 4'd9);
        idle(1);

        // running dropped mid pulse 4
        repeat (3) send_pulse(8, 1);
        repeat (4) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        check_result("abort", 1'b1, 3'd5, 4'd3);
        idle(1);

        // Asynchronous reset mid pulse 4
        repeat (3) send_pulse(8, 1);
        repeat (4) cyc(1'b1, 1'b1, 1'b0);
        check("pre_rst_busy", 16'(busy), 16'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", 16'(busy), 16'd0);
        check("arst_cnt",  16'(pulse_count), 16'd0);
        check("arst_fail", 16'(fail), 16'd0);
        check("arst_err",  16'(err_code), 16'd0);
        running_in = 1'b0;
        pulse_in   = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(1);

        // No pulse after arm: arm cycle + 4 low cycles tolerated, fail on the 5th
        cyc(1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        check("start_to_edge_fail", 16'(fail), 16'd0);
        check("start_to_edge_busy", 16'(busy), 16'd1);
        cyc(1'b1, 1'b0, 1'b0);
        check_result("start_to", 1'b1, 3'd4, 4'd0);
`ifdef PULSE_CHK_TIMESTAMP_EN
        check("fail_cycle", fail_cycle, 16'd4);
`endif
        idle(1);

        // First pulse on the last allowed cycle is accepted
        repeat (4) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        check("late_start_fail", 16'(fail), 16'd0);
        check("late_start_busy", 16'(busy), 16'd1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
